sequential_read_capture_fifo: RTL
=================================

// Module: sequential_read_capture_fifo
// PURPOSE
//  Downstream stage of the sequential AXI-Lite read master: captures the R-channel beats it
//  produces (data + RRESP) into a FIFO, frames them into sequences of BURST_LEN words, and
//  presents them to a valid/ready consumer. Flags slave error responses, reports sequence
//  completion. Sits between the read master's R beat output and the processing datapath.
// PARAMETERS
//  DATA_WIDTH  32  width of captured read data / output word
//  DEPTH       16  FIFO entries; power of 2, >=2
//  BURST_LEN    8  beats per sequence (one per TXN_INIT); 1..255
// PORTS
//  ACLK        in   1           single clock, all logic rising-edge
//  ARESET      in   1           reset, synchronous, active-high
//  TXN_INIT    in   1           1-cycle pulse: start new capture sequence
//  in_valid    in   1           read master presents an R beat
//  in_ready    out  1           beat accepted when in_valid & in_ready
//  in_data     in   DATA_WIDTH  RDATA of beat
//  in_resp     in   2           RRESP of beat
//  out_valid   out  1           FIFO head valid
//  out_ready   in   1           consumer pops head when out_valid & out_ready
//  out_data    out  DATA_WIDTH  FIFO head data
//  out_last    out  1           head word is final beat of its sequence
//  level       out  $clog2(DEPTH)+1  current FIFO occupancy
//  seq_done    out  1           1-cycle pulse: BURST_LEN beats accepted
//  seq_error   out  1           sticky: some beat of current sequence had RRESP[1]=1
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, ptrs/level/beat_cnt=0, in_ready=0, out_valid=0, out_last=0, seq_done=0,
//   seq_error=0; FIFO contents discarded. Reset mid-sequence aborts with no seq_done.
//  FSM: IDLE -> COLLECT on TXN_INIT. COLLECT -> DONE on acceptance of beat BURST_LEN-1.
//   DONE (exactly 1 cycle, seq_done=1, in_ready=0) -> IDLE. TXN_INIT in DONE ignored.
//  in_ready = (state==COLLECT) & !full & !TXN_INIT (combinational).
//  TXN_INIT in COLLECT: restart; beat_cnt<=0, seq_error<=0, stay COLLECT; no beat accepted
//   that cycle; words already in FIFO retained (out_last unchanged for them).
//  TXN_INIT in IDLE also clears seq_error; otherwise seq_error holds after DONE until next init.
//  Accepted beat: write {last,data} at wr_ptr, last = (beat_cnt==BURST_LEN-1); beat_cnt++;
//   if in_resp[1] then seq_error<=1 next cycle. Data of error beats still stored.
//  Output: FWFT; out_data/out_last = mem[rd_ptr]; out_valid = (level!=0). Word accepted at edge
//   N appears at output after edge N (1-cycle latency) when FIFO was empty.
//  Simultaneous push+pop: level unchanged, both ptrs advance; allowed when full only if pop
//   occurs (in_ready still 0 when full -- no push at full, no bypass).
//  Empty: out_ready ignored, no pointer movement. Pointers wrap mod DEPTH; level never >DEPTH.
//  seq_done asserts the cycle after the last beat is accepted (in DONE), independent of drain.
//  Backpressure: consumer stall fills FIFO; in_ready drops at level==DEPTH; resumes the cycle
//   after a pop lowers level.
// TESTING
//  1 Reset, TXN_INIT, 8 beats 0x100..0x107 RRESP=0, out_ready=1 -> 8 pops in order, out_last
//    only on 0x107, seq_done 1 cycle after 8th accept, seq_error=0.
//  2 DEPTH=16, out_ready=0, two sequences (16 beats) -> in_ready=0 at level=16; 17th beat
//    held; one pop -> in_ready=1 next cycle, level stays 16 after push.
//  3 Beat 3 with RRESP=2'b10 -> seq_error=1 from next cycle through DONE; data still popped;
//    next TXN_INIT clears seq_error.
//  4 TXN_INIT after 5 beats, in_valid held high -> no accept that cycle; 8 more beats needed
//    for seq_done; first 5 words popped with out_last=0.
//  5 Simultaneous push/pop at level=4 over 10 cycles -> level constant 4, data order preserved.
//  6 ARESET asserted after 3 beats -> next cycle out_valid=0, level=0, in_ready=0, no seq_done.

Source files
------------

// File: rtl/sequential_read_capture_fifo.sv
// Captures AXI-Lite R beats into a FWFT FIFO, frames them into BURST_LEN-word sequences with per-word last flags.
// Latency: a beat accepted at edge N is visible at out_* after edge N; seq_done pulses the cycle after the final accept.
// Backpressure: in_ready drops while the FIFO is full, outside COLLECT, or during a TXN_INIT cycle; push needs a free slot.
module sequential_read_capture_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       TXN_INIT,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [1:0]                 in_resp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       seq_done,
  output logic                       seq_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state_q;
  logic [7:0]            beat_cnt_q;
  logic                  seq_done_q;
  logic                  seq_error_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  last_beat;
  logic [DATA_WIDTH:0]   head;
  logic                  unused_resp0;

  // Only the error bit (RRESP[1]) matters; OKAY/EXOKAY are not distinguished.
  assign unused_resp0 = in_resp[0];

  assign full      = (level_q == LW'(DEPTH));
  assign in_ready  = (state_q == COLLECT) && !full && !TXN_INIT;
  assign push      = in_valid && in_ready;
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  assign last_beat = (beat_cnt_q == 8'(BURST_LEN - 1));

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head[DATA_WIDTH-1:0];
  // Gate the stored flag so a stale entry never shows last while empty.
  assign out_last  = out_valid && head[DATA_WIDTH];
  assign level     = level_q;
  assign seq_done  = seq_done_q;
  assign seq_error = seq_error_q;

  // Sequence framing FSM: tracks beats per sequence, error flag and completion pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      seq_done_q  <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      seq_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (TXN_INIT) begin
            state_q     <= COLLECT;
            beat_cnt_q  <= '0;
            seq_error_q <= 1'b0;
          end
        end
        COLLECT: begin
          if (TXN_INIT) begin
            // Restart framing; words already queued keep their flags.
            beat_cnt_q  <= '0;
            seq_error_q <= 1'b0;
          end else if (push) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (in_resp[1]) begin
              seq_error_q <= 1'b1;
            end
            if (last_beat) begin
              state_q    <= DONE;
              seq_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {last_beat, in_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-2 DEPTH.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

endmodule
